turn_input_checker: RTL and testbench
=====================================

TURN_INPUT_CHECKER -- requirements
Module: turn_input_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of player switches.
REQ-002 SHALL have parameter MODE, default 0: legal move is 0 = exactly one bit 1->0, 1 = exactly one bit 0->1, 2 = exactly one bit toggled either way.
REQ-003 SHALL have parameter STABLE_CYCLES, default 4 (legal range >= 1): consecutive cycles a change must hold before it is judged.
REQ-004 SHALL have parameter CNT_W, default 8: width of the move counter.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 sw  input  WIDTH  current switch state.
REQ-009 arm  input  1  single-cycle pulse that starts a turn and captures the baseline.
REQ-010 ok  output  1  single-cycle pulse: legal move judged.
REQ-011 err  output  1  single-cycle pulse: illegal move judged.
REQ-012 bit_idx  output  $clog2(WIDTH)  index of the changed bit; valid only while ok=1.
REQ-013 busy  output  1  high from arm acceptance until the verdict cycle, inclusive.
REQ-014 move_count  output  CNT_W  number of legal moves accepted.

Function
REQ-015 States SHALL be IDLE, ARMED, SETTLE and JUDGE; all outputs SHALL be registered.
REQ-016 IDLE: on arm=1, sw SHALL be latched into base, state -> ARMED, busy=1 from the next cycle.
REQ-017 arm SHALL be ignored in every state other than IDLE.
REQ-018 ARMED: at any edge E0 with sw != base, sw SHALL be latched into cand, stable counter set to 1, state -> SETTLE.
REQ-019 SETTLE with sw == cand: counter SHALL increment; at counter == STABLE_CYCLES the state SHALL go to JUDGE.
REQ-020 SETTLE with sw == base: state SHALL return to ARMED and counter clear (bounce back, no verdict).
REQ-021 SETTLE with sw != cand and sw != base: cand SHALL reload with sw and counter reset to 1.
REQ-022 With STABLE_CYCLES=1, ARMED SHALL go directly to JUDGE at E0.
REQ-023 ok or err SHALL be high during the cycle following edge E0+STABLE_CYCLES.
REQ-024 JUDGE: d = base XOR cand; the move SHALL be legal iff popcount(d)==1 and the direction matches MODE (bit cleared in cand for MODE 0, bit set for MODE 1, either for MODE 2).
REQ-025 Legal: ok=1 for one cycle, bit_idx = index of the set bit of d, move_count increments.
REQ-026 Illegal: err=1 for one cycle, bit_idx=0, move_count unchanged.
REQ-027 ok and err SHALL never be high together.
REQ-028 JUDGE SHALL return to IDLE after one cycle; arm is accepted from the following cycle.
REQ-029 move_count SHALL saturate at all-ones and SHALL NOT wrap.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, and ok=0, err=0, busy=0, bit_idx=0, move_count=0, base=0, cand=0, counter=0, regardless of state, including mid-SETTLE or JUDGE.

Configuration
REQ-031 Macro TURN_MOVE_COUNTER_EN defined: move_count SHALL behave per REQ-025/029; undefined: the counter register SHALL NOT be built and move_count SHALL be tied to 0.

Verification
REQ-032 WIDTH=16, MODE=0, STABLE_CYCLES=4: arm with sw=0x0007, sw->0x0006 held -> ok pulse after E0+4, bit_idx=0, move_count=1.
REQ-033 Same config: arm with sw=0x0004, sw->0x0007 held -> err pulse, ok=0, move_count unchanged.
REQ-034 Bounce: base 0x0007, sw=0x0006 for 2 cycles, then 0x0007, then 0x0005 held -> no verdict until 0x0005 has held 4 cycles, then ok with bit_idx=1.
REQ-035 MODE=1: base 0x0000, sw->0x8000 held -> ok with bit_idx=15; with MODE=0 the same stimulus -> err.
REQ-036 reset pulsed mid-SETTLE -> all outputs 0 within the same cycle, no ok/err afterwards, and arm is accepted after reset deasserts.
REQ-037 Saturation and macro: with CNT_W=2, 4 legal moves -> move_count=3; with the macro undefined -> move_count=0 throughout.

Source files
------------

// File: rtl/turn_input_checker.sv
// Turn-based switch move checker: arms on a baseline, debounces a single change, judges legality.
// Optional macro TURN_MOVE_COUNTER_EN builds the saturating legal-move counter; otherwise move_count is 0.
module turn_input_checker #(
    parameter int WIDTH         = 16,
    parameter int MODE          = 0,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           sw,
    input  logic                       arm,
    output logic                       ok,
    output logic                       err,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic                       busy,
    output logic [CNT_W-1:0]           move_count
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, SETTLE, JUDGE} state_t;

    state_t             state_r, state_n;
    logic [WIDTH-1:0]   base_r, base_n, cand_r, cand_n;
    logic [STB_W-1:0]   cnt_r, cnt_n;
    logic               ok_r, ok_n, err_r, err_n, busy_r, busy_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [WIDTH-1:0]   diff_s;
    logic [IDX_W-1:0]   diff_idx_s;
    logic               one_hot_s, dir_ok_s, legal_s;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [IDX_W-1:0] set_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = v[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    // Legality of the settled candidate relative to the baseline
    always_comb begin
        diff_s     = base_r ^ cand_r;
        one_hot_s  = (popcount(diff_s) == PC_W'(1));
        diff_idx_s = set_index(diff_s);
        case (MODE)
            0:       dir_ok_s = ((diff_s & cand_r) == '0);
            1:       dir_ok_s = ((diff_s & base_r) == '0);
            2:       dir_ok_s = 1'b1;
            default: dir_ok_s = 1'b0;
        endcase
        legal_s = one_hot_s & dir_ok_s;
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state_r;
        base_n  = base_r;
        cand_n  = cand_r;
        cnt_n   = cnt_r;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        idx_n   = '0;
        case (state_r)
            IDLE: begin
                if (arm) begin
                    base_n  = sw;
                    state_n = ARMED;
                end else begin
                    state_n = IDLE;
                end
            end
            ARMED: begin
                if (sw != base_r) begin
                    cand_n  = sw;
                    cnt_n   = STB_W'(1);
                    state_n = (STABLE_CYCLES <= 1) ? JUDGE : SETTLE;
                end else begin
                    cnt_n   = '0;
                    state_n = ARMED;
                end
            end
            SETTLE: begin
                if (sw == base_r) begin
                    cnt_n   = '0;
                    state_n = ARMED;
                end else if (sw == cand_r) begin
                    cnt_n   = cnt_r + STB_W'(1);
                    state_n = (cnt_n == STB_W'(STABLE_CYCLES)) ? JUDGE : SETTLE;
                end else begin
                    cand_n  = sw;
                    cnt_n   = STB_W'(1);
                    state_n = SETTLE;
                end
            end
            JUDGE: begin
                cnt_n   = '0;
                state_n = IDLE;
                if (legal_s) begin
                    ok_n  = 1'b1;
                    idx_n = diff_idx_s;
                end else begin
                    err_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // busy covers the verdict cycle, which is spent in IDLE after leaving JUDGE
        busy_n = (state_n != IDLE) || (state_r == JUDGE);
    end

    // State, capture and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            base_r  <= '0;
            cand_r  <= '0;
            cnt_r   <= '0;
            ok_r    <= 1'b0;
            err_r   <= 1'b0;
            idx_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            base_r  <= base_n;
            cand_r  <= cand_n;
            cnt_r   <= cnt_n;
            ok_r    <= ok_n;
            err_r   <= err_n;
            idx_r   <= idx_n;
            busy_r  <= busy_n;
        end
    end

`ifdef TURN_MOVE_COUNTER_EN
    logic [CNT_W-1:0] count_r;

    // Saturating count of legal verdicts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (ok_n && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign move_count = count_r;
`else
    assign move_count = '0;
`endif

    assign ok      = ok_r;
    assign err     = err_r;
    assign bit_idx = idx_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_turn_input_checker.sv
// Self-checking bench: three checker configurations driven by shared directed and random stimulus,
// compared every cycle against a run-length based turn model.
module tb_turn_input_checker;
`ifdef TURN_MOVE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int SC    [3] = '{4, 4, 1};
    localparam int MD    [3] = '{0, 1, 2};
    localparam int MCMAX [3] = '{255, 255, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        arm;
    logic        ok_v [3];
    logic        err_v [3];
    logic        busy_v [3];
    logic [3:0]  idx_v [3];
    logic [7:0]  mc0, mc1;
    logic [1:0]  mc2;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    turn_input_checker #(.WIDTH(16), .MODE(0), .STABLE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk(clk), .reset(rst), .sw(sw), .arm(arm), .ok(ok_v[0]), .err(err_v[0]),
        .bit_idx(idx_v[0]), .busy(busy_v[0]), .move_count(mc0));
    turn_input_checker #(.WIDTH(16), .MODE(1), .STABLE_CYCLES(4), .CNT_W(8)) dut1 (
        .clk(clk), .reset(rst), .sw(sw), .arm(arm), .ok(ok_v[1]), .err(err_v[1]),
        .bit_idx(idx_v[1]), .busy(busy_v[1]), .move_count(mc1));
    turn_input_checker #(.WIDTH(16), .MODE(2), .STABLE_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(rst), .sw(sw), .arm(arm), .ok(ok_v[2]), .err(err_v[2]),
        .bit_idx(idx_v[2]), .busy(busy_v[2]), .move_count(mc2));

    // Model: phase 0 idle, 1 turn in progress, 2 verdict due at next edge
    int          phase [3];
    logic [15:0] mbase [3];
    logic [15:0] mrun  [3];
    int          mlen  [3];
    bit          e_ok  [3];
    bit          e_err [3];
    bit          e_busy[3];
    int          e_idx [3];
    int          e_mc  [3];

    function automatic bit legal_move(input logic [15:0] b, input logic [15:0] c,
                                      input int mode, output int idx);
        logic [15:0] dlt;
        dlt = b ^ c;
        idx = 0;
        if ($countones(dlt) != 1) return 1'b0;
        for (int i = 0; i < 16; i++) if (dlt[i]) idx = i;
        if (mode == 0) return c[idx] == 1'b0;
        if (mode == 1) return c[idx] == 1'b1;
        return 1'b1;
    endfunction

    function automatic int mc_of(input int d);
        case (d)
            0:       return int'(mc0);
            1:       return int'(mc1);
            default: return int'(mc2);
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 3; d++) begin
            bit verdict;
            int ix;
            verdict = 1'b0;
            e_ok[d] = 1'b0; e_err[d] = 1'b0; e_idx[d] = 0;
            if (rst) begin
                phase[d] = 0; mbase[d] = '0; mrun[d] = '0; mlen[d] = 0; e_mc[d] = 0;
            end else if (phase[d] == 0) begin
                if (arm) begin mbase[d] = sw; mlen[d] = 0; phase[d] = 1; end
            end else if (phase[d] == 1) begin
                if (sw == mbase[d]) mlen[d] = 0;
                else if (mlen[d] > 0 && sw == mrun[d]) mlen[d]++;
                else begin mrun[d] = sw; mlen[d] = 1; end
                if (mlen[d] == SC[d]) phase[d] = 2;
            end else begin
                verdict = 1'b1;
                phase[d] = 0;
                if (legal_move(mbase[d], mrun[d], MD[d], ix)) begin
                    e_ok[d] = 1'b1; e_idx[d] = ix;
                    if (CNT_EN && e_mc[d] < MCMAX[d]) e_mc[d]++;
                end else begin
                    e_err[d] = 1'b1;
                end
            end
            e_busy[d] = !rst && (phase[d] != 0 || verdict);
        end
    end

    task automatic check(input string nm, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int d = 0; d < 3; d++) begin
                check("ok", d, int'(ok_v[d]), int'(e_ok[d]));
                check("err", d, int'(err_v[d]), int'(e_err[d]));
                check("busy", d, int'(busy_v[d]), int'(e_busy[d]));
                check("move_count", d, mc_of(d), e_mc[d]);
                if (e_ok[d] || e_err[d]) check("bit_idx", d, int'(idx_v[d]), e_idx[d]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic turn(input logic [15:0] b, input logic [15:0] m, input int n);
        sw = b; arm = 1'b1;
        cyc(1);
        arm = 1'b0; sw = m;
        cyc(n);
    endtask

    initial begin
        sw = '0; arm = 1'b0; rst = 1'b1;
        cyc(3);
        for (int d = 0; d < 3; d++) begin
            check("rst_ok", d, int'(ok_v[d]), 0);
            check("rst_busy", d, int'(busy_v[d]), 0);
            check("rst_mc", d, mc_of(d), 0);
        end
        rst = 1'b0; chk_en = 1'b1;
        cyc(2);

        turn(16'h0007, 16'h0006, 5);
        check("legal_ok", 0, int'(ok_v[0]), 1);
        check("legal_idx", 0, int'(idx_v[0]), 0);
        check("mode1_err", 1, int'(err_v[1]), 1);
        cyc(1);
        check("legal_mc", 0, int'(mc0), CNT_EN ? 1 : 0);

        turn(16'h0004, 16'h0007, 5);
        check("illegal_err", 0, int'(err_v[0]), 1);
        check("illegal_ok", 0, int'(ok_v[0]), 0);
        cyc(1);
        check("illegal_mc", 0, int'(mc0), CNT_EN ? 1 : 0);

        sw = 16'h0007; arm = 1'b1;
        cyc(1);
        arm = 1'b0; sw = 16'h0006;
        cyc(2);
        sw = 16'h0007;
        cyc(1);
        sw = 16'h0005;
        cyc(4);
        check("bounce_early_ok", 0, int'(ok_v[0]), 0);
        check("bounce_busy", 0, int'(busy_v[0]), 1);
        cyc(1);
        check("bounce_ok", 0, int'(ok_v[0]), 1);
        check("bounce_idx", 0, int'(idx_v[0]), 1);
        cyc(1);

        turn(16'h0000, 16'h8000, 5);
        check("set_ok", 1, int'(ok_v[1]), 1);
        check("set_idx", 1, int'(idx_v[1]), 15);
        check("set_err_mode0", 0, int'(err_v[0]), 1);
        cyc(1);

        for (int k = 0; k < 4; k++) begin
            turn(16'h000F, 16'h000E, 5);
            cyc(1);
        end
        check("sat_mc", 2, int'(mc2), CNT_EN ? 3 : 0);

        sw = 16'h0007; arm = 1'b1;
        cyc(1);
        arm = 1'b0; sw = 16'h0006;
        cyc(2);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 0, int'(busy_v[0]), 0);
        check("midrst_ok", 0, int'(ok_v[0]), 0);
        check("midrst_mc", 0, int'(mc0), 0);
        check("midrst_mc", 2, int'(mc2), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(6);
        arm = 1'b1;
        cyc(1);
        arm = 1'b0;
        check("rearm_busy", 0, int'(busy_v[0]), 1);
        cyc(1);

        for (int t = 0; t < 3000; t++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r < 3) sw[$urandom_range(0, 15)] = ~sw[$urandom_range(0, 15)];
            else if (r == 3) sw = 16'($urandom);
            else if (r == 4) sw = sw ^ (16'h0001 << $urandom_range(0, 15)) ^ 16'h0100;
            else if (r == 5) sw = sw ^ (16'h0001 << $urandom_range(0, 15));
            else sw = sw;
            arm = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        arm = 1'b0;
        cyc(8);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
